// File: rtl/boid_fb_writer_if.sv
// Bundles the boid slot-update port and the pixel RAM write port of the
// boid framebuffer writer. The writer uses the master modport: it drives
// the RAM write bus and receives slot updates. The parent uses slave.
interface boid_fb_writer_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 9,
    parameter int IDX_W      = 4
);
    logic                  pos_we;
    logic [IDX_W-1:0]      pos_idx;
    logic [9:0]            pos_x;
    logic [8:0]            pos_y;
    logic                  pos_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;

    modport master (
        input  pos_we, pos_idx, pos_x, pos_y, pos_en,
        output wr_addr, wr_data, wr_en
    );

    modport slave (
        output pos_we, pos_idx, pos_x, pos_y, pos_en,
        input  wr_addr, wr_data, wr_en
    );
endinterface

// File: rtl/boid_fb_writer.sv
// Boid framebuffer writer. Once per frame it erases every boid's previous
// square with the background index, then draws every boid's current square
// with the boid index, one pixel slot per clock. Every slot costs exactly one
// cycle whether or not it writes, so frame timing is fixed.
module boid_fb_writer #(
    parameter int NUM_BOIDS  = 16,
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 9,
    parameter int BOID_SIZE  = 2,
    parameter int BG_COLOR   = 31,
    parameter int BOID_COLOR = 42
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    boid_fb_writer_if.master       fb,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);
    localparam int IDX_W = $clog2(NUM_BOIDS);
    localparam int SQ    = BOID_SIZE * BOID_SIZE;
    localparam int SLOTS = NUM_BOIDS * SQ;
    localparam int K_W   = $clog2(SLOTS);
    localparam logic [K_W-1:0] K_LAST = K_W'(SLOTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Shadow table (written any time), snapshot for this frame, last frame.
    logic [9:0]           sh_x_r   [NUM_BOIDS];
    logic [8:0]           sh_y_r   [NUM_BOIDS];
    logic [NUM_BOIDS-1:0] sh_en_r;
    logic [9:0]           cur_x_r  [NUM_BOIDS];
    logic [8:0]           cur_y_r  [NUM_BOIDS];
    logic [NUM_BOIDS-1:0] cur_en_r;
    logic [9:0]           prev_x_r [NUM_BOIDS];
    logic [8:0]           prev_y_r [NUM_BOIDS];
    logic [NUM_BOIDS-1:0] prev_en_r;

    state_t                state_r;
    logic [K_W-1:0]        k_r;
    logic                  fs_d_r;
    logic                  busy_r;
    logic                  frame_done_r;
    logic                  overrun_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;
    logic                  wr_en_r;

    logic                  fs_edge_s;
    logic [IDX_W-1:0]      boid_s;
    logic [10:0]           dx_s;
    logic [9:0]            dy_s;
    logic [9:0]            sel_x_s;
    logic [8:0]            sel_y_s;
    logic                  sel_en_s;
    logic [10:0]           px_s;
    logic [9:0]            py_s;
    logic                  vis_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] data_s;

    assign fs_edge_s  = frame_start & ~fs_d_r;
    assign fb.wr_addr = wr_addr_r;
    assign fb.wr_data = wr_data_r;
    assign fb.wr_en   = wr_en_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign overrun    = overrun_r;

    // Delayed frame_start for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_d_r <= 1'b0;
        end else begin
            fs_d_r <= frame_start;
        end
    end

    // Shadow table: slot updates accepted at any time, including while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BOIDS; i++) begin
                sh_x_r[i] <= 10'd0;
                sh_y_r[i] <= 9'd0;
            end
            sh_en_r <= {NUM_BOIDS{1'b0}};
        end else if (fb.pos_we) begin
            sh_x_r[fb.pos_idx]  <= fb.pos_x;
            sh_y_r[fb.pos_idx]  <= fb.pos_y;
            sh_en_r[fb.pos_idx] <= fb.pos_en;
        end
    end

    // Decode the current slot into a pixel: boid index, offsets, clip, address.
    always_comb begin
        boid_s = IDX_W'(32'(k_r) / SQ);
        dx_s   = 11'((32'(k_r) % SQ) % BOID_SIZE);
        dy_s   = 10'((32'(k_r) % SQ) / BOID_SIZE);
        if (state_r == ST_ERASE) begin
            sel_x_s  = prev_x_r[boid_s];
            sel_y_s  = prev_y_r[boid_s];
            sel_en_s = prev_en_r[boid_s];
            data_s   = DATA_WIDTH'(BG_COLOR);
        end else begin
            sel_x_s  = cur_x_r[boid_s];
            sel_y_s  = cur_y_r[boid_s];
            sel_en_s = cur_en_r[boid_s];
            data_s   = DATA_WIDTH'(BOID_COLOR);
        end
        // Widened by one bit so pixels past the right/bottom edge clip instead of wrapping.
        px_s   = {1'b0, sel_x_s} + dx_s;
        py_s   = {1'b0, sel_y_s} + dy_s;
        vis_s  = sel_en_s & (px_s < 11'(WIDTH)) & (py_s < 10'(HEIGHT));
        addr_s = ADDR_WIDTH'(32'(px_s) + 32'(WIDTH) * 32'(py_s));
    end

    // Frame sequencer with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            k_r          <= {K_W{1'b0}};
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            wr_addr_r    <= {ADDR_WIDTH{1'b0}};
            wr_data_r    <= {DATA_WIDTH{1'b0}};
            wr_en_r      <= 1'b0;
            for (int i = 0; i < NUM_BOIDS; i++) begin
                cur_x_r[i]  <= 10'd0;
                cur_y_r[i]  <= 9'd0;
                prev_x_r[i] <= 10'd0;
                prev_y_r[i] <= 9'd0;
            end
            cur_en_r  <= {NUM_BOIDS{1'b0}};
            prev_en_r <= {NUM_BOIDS{1'b0}};
        end else begin
            // A new frame request while one is in flight is dropped but remembered.
            overrun_r <= overrun_r | (fs_edge_s & busy_r);
            case (state_r)
                ST_IDLE: begin
                    wr_en_r      <= 1'b0;
                    frame_done_r <= 1'b0;
                    if (fs_edge_s) begin
                        cur_x_r  <= sh_x_r;
                        cur_y_r  <= sh_y_r;
                        cur_en_r <= sh_en_r;
                        k_r      <= {K_W{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_ERASE;
                    end
                end
                ST_ERASE: begin
                    wr_en_r   <= vis_s;
                    wr_addr_r <= addr_s;
                    wr_data_r <= data_s;
                    if (k_r == K_LAST) begin
                        k_r     <= {K_W{1'b0}};
                        state_r <= ST_DRAW;
                    end else begin
                        k_r <= k_r + {{(K_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DRAW: begin
                    wr_en_r   <= vis_s;
                    wr_addr_r <= addr_s;
                    wr_data_r <= data_s;
                    if (k_r == K_LAST) begin
                        k_r          <= {K_W{1'b0}};
                        frame_done_r <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        k_r <= k_r + {{(K_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    wr_en_r      <= 1'b0;
                    frame_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                    prev_x_r     <= cur_x_r;
                    prev_y_r     <= cur_y_r;
                    prev_en_r    <= cur_en_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    wr_en_r      <= 1'b0;
                    frame_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
